// File: rtl/pipe_disp_pkg.sv
// Shared constants and state encoding for the input-pipe dispatcher.
package pipe_disp_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  localparam int HDR_SYNC_H = 31;
  localparam int HDR_SYNC_L = 24;
  localparam int HDR_CH_H   = 23;
  localparam int HDR_CH_L   = 16;
  localparam int HDR_LEN_H  = 15;
  localparam int HDR_LEN_L  = 0;

  typedef enum logic {
    S_HDR  = 1'b0,
    S_DATA = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_sync_fifo.sv
// Single-clock FIFO with registered storage; head is the oldest buffered word.
module pipe_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/pipe_in_dispatcher.sv
// Buffers the host pipe word stream, parses packet headers and forwards
// payload words to the addressed channel over valid/ready.
module pipe_in_dispatcher
  import pipe_disp_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ti_clk,
  input  logic                          ti_reset,
  input  logic                          pipe_write,
  input  logic [31:0]                   pipe_data,
  output logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH-1:0]             ch_ready,
  output logic [31:0]                   ch_data,
  output logic                          ch_last,
  input  logic                          clear_err,
  output logic                          overflow,
  output logic                          bad_header,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              bad_q, bad_d;

  logic [31:0]       fifo_head;
  logic              fifo_pop, fifo_full, fifo_empty;

  logic [7:0]        hdr_sync, hdr_ch;
  logic [15:0]       hdr_len;
  logic              hdr_ok;

  pipe_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ti_clk),
    .rst   (ti_reset),
    .push  (pipe_write),
    .din   (pipe_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign hdr_sync = fifo_head[HDR_SYNC_H:HDR_SYNC_L];
  assign hdr_ch   = fifo_head[HDR_CH_H:HDR_CH_L];
  assign hdr_len  = fifo_head[HDR_LEN_H:HDR_LEN_L];
  assign hdr_ok   = (hdr_sync == SYNC_BYTE) && (hdr_ch < 8'(NUM_CH));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    ch_valid = '0;
    ovf_d    = clear_err ? 1'b0 : ovf_q;
    bad_d    = clear_err ? 1'b0 : bad_q;

    // Error setting comes after the clear so a same-cycle error keeps the flag.
    if (pipe_write && fifo_full) ovf_d = 1'b1;

    case (state_q)
      S_HDR: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!hdr_ok) begin
            bad_d = 1'b1;
          end else if (hdr_len != '0) begin
            sel_d   = hdr_ch[SEL_W-1:0];
            cnt_d   = hdr_len;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          ch_valid[i] = !fifo_empty && (sel_q == SEL_W'(i));
        if (!fifo_empty && ch_ready[sel_q]) begin
          fifo_pop = 1'b1;
          cnt_d    = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_HDR;
        end
      end
    endcase
  end

  assign ch_data    = fifo_head;
  assign ch_last    = (|ch_valid) && (cnt_q == 16'd1);
  assign busy       = (state_q == S_DATA) || !fifo_empty;
  assign overflow   = ovf_q;
  assign bad_header = bad_q;

  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      state_q <= S_HDR;
      sel_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

endmodule
